// File: rtl/mux21_rr_arbiter.sv
// mux21_rr_arbiter: round-robin sharing of one 2:1 mux between two bursting requesters; `define ARB_TIMEOUT_EN to revoke stalled grants.
// Latency: gnt one cycle after req in IDLE; a transferred beat appears on out_data the following cycle.
// Backpressure: single output register loads when empty or draining on out_ready, otherwise holds data/last stable.
module mux21_rr_arbiter #(
  parameter int WIDTH       = 8,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [1:0]       last,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  output logic [1:0]       gnt,
  output logic             s,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
`ifdef ARB_TIMEOUT_EN
  output logic             timeout_flag,
`endif
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t state, state_nxt;
  logic   s_nxt;
  logic   ptr, ptr_nxt;
  logic   stage_free;
  logic   xfer;
  logic   timeout;

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_timeout_range
    $error("mux21_rr_arbiter: TIMEOUT_CYC must be within 1..255");
  end

  assign stage_free = !out_valid || out_ready;

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    ptr_nxt   = ptr;
    gnt       = 2'b00;
    busy      = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          state_nxt = BUSY;
          // Contention resolved by ptr; a lone requester wins outright.
          s_nxt     = (req == 2'b11) ? ptr : req[1];
        end
      end
      BUSY: begin
        busy = 1'b1;
        gnt  = s ? 2'b10 : 2'b01;
        xfer = req[s] && stage_free;
        if ((xfer && last[s]) || timeout) begin
          ptr_nxt   = ~s;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      s     <= 1'b0;
      ptr   <= 1'b0;
    end else begin
      state <= state_nxt;
      s     <= s_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Load and drain in the same cycle keeps out_valid high for full throughput.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= s ? i1 : i0;
      out_last  <= last[s];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] idle_cnt;

  assign timeout = (state == BUSY) && !req[s] && ((idle_cnt + 8'd1) == 8'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt     <= 8'd0;
      timeout_flag <= 1'b0;
    end else begin
      if (state == IDLE || xfer || timeout) begin
        idle_cnt <= 8'd0;
      end else if (!req[s]) begin
        idle_cnt <= idle_cnt + 8'd1;
      end
      if (timeout) begin
        timeout_flag <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mux21_rr_arbiter.sv
// Bench for mux21_rr_arbiter: per-requester source queues, expected-beat scoreboard, grant/timing checks.
module tb_mux21_rr_arbiter;
  localparam int WIDTH = 8;
  localparam int TO    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req;
  logic [1:0]       last;
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic [1:0]       gnt;
  logic             s;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_ready;
  logic             busy;
`ifdef ARB_TIMEOUT_EN
  logic             timeout_flag;
`endif

  always #5 clk = ~clk;

  mux21_rr_arbiter #(.WIDTH(WIDTH), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .last        (last),
    .i0          (i0),
    .i1          (i1),
    .gnt         (gnt),
    .s           (s),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready),
`ifdef ARB_TIMEOUT_EN
    .timeout_flag(timeout_flag),
`endif
    .busy        (busy)
  );

  // Beats are {last, data}.
  logic [WIDTH:0] q0[$];
  logic [WIDTH:0] q1[$];
  logic [WIDTH:0] sb[$];
  logic [1:0]     take;
  logic [1:0]     stall;
  logic [1:0]     stall_nxt;
  logic           ready_nxt;
  int             n_cmp = 0;
  int             n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, want);
    end
  endtask

  // Just after the rising edge: retire accepted beats, then present the next ones.
  task automatic pos();
    @(posedge clk);
    #1;
    if (take[0] && q0.size() != 0) q0.delete(0);
    if (take[1] && q1.size() != 0) q1.delete(0);
    take      = 2'b00;
    out_ready = ready_nxt;
    stall     = stall_nxt;
    req[0]    = (q0.size() != 0) && !stall[0];
    req[1]    = (q1.size() != 0) && !stall[1];
    i0        = (q0.size() != 0) ? q0[0][WIDTH-1:0] : '0;
    i1        = (q1.size() != 0) ? q1[0][WIDTH-1:0] : '0;
    last[0]   = (q0.size() != 0) && q0[0][WIDTH];
    last[1]   = (q1.size() != 0) && q1[0][WIDTH];
  endtask

  // Mid-cycle: note which source beat the coming edge accepts, and score the drained output beat.
  task automatic neg();
    @(negedge clk);
    take[0] = rst_n && gnt[0] && req[0] && (!out_valid || out_ready);
    take[1] = rst_n && gnt[1] && req[1] && (!out_valid || out_ready);
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_beat", 32'(sb.size()), 32'd1);
      end else begin
        chk("beat", 32'({out_last, out_data}), 32'(sb[0]));
        sb.delete(0);
      end
    end
  endtask

  task automatic cyc();
    pos();
    neg();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0 || busy || out_valid) && n < 80) begin
      cyc();
      n++;
    end
    chk(tag, 32'(q0.size() + q1.size() + sb.size()) + 32'(busy) + 32'(out_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    sb.delete();
    take = 2'b00;
    pos();
    pos();
    rst_n = 1'b1;
    neg();
  endtask

  initial begin
    rst_n = 1'b0; req = 2'b00; last = 2'b00; i0 = '0; i1 = '0;
    out_ready = 1'b1; ready_nxt = 1'b1; stall = 2'b00; stall_nxt = 2'b00; take = 2'b00;
    do_reset();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a burst.
    q0 = '{9'h05A, 9'h05B, 9'h15C};
    sb = '{9'h05A};
    cyc();
    cyc();
    cyc();
    chk("mid_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'd0);
    chk("async_rst_s", 32'(s), 32'd0);
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    do_reset();

    // Single requester, 3-beat burst at full rate.
    q0 = '{9'h011, 9'h022, 9'h133};
    sb = '{9'h011, 9'h022, 9'h133};
    cyc();
    chk("single_idle_gnt", 32'(gnt), 32'd0);
    cyc();
    chk("single_gnt", 32'(gnt), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_s", 32'(s), 32'd0);
    cyc();
    chk("single_b0", 32'(out_data), 32'h11);
    cyc();
    chk("single_b1", 32'(out_data), 32'h22);
    cyc();
    chk("single_b2", 32'(out_data), 32'h33);
    chk("single_b2_last", 32'(out_last), 32'd1);
    chk("single_end_gnt", 32'(gnt), 32'd0);
    drain("single_drain");

    // Contention from reset: 1-beat bursts alternate with one idle bubble.
    do_reset();
    q0 = '{9'h1A0, 9'h1A0};
    q1 = '{9'h1B1, 9'h1B1};
    sb = '{9'h1A0, 9'h1B1, 9'h1A0, 9'h1B1};
    cyc();
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("cont_gnt", 32'(gnt), k[0] ? 32'd2 : 32'd1);
      chk("cont_s", 32'(s), 32'(k[0]));
      cyc();
      chk("cont_bubble", 32'(gnt), 32'd0);
    end
    drain("cont_drain");

    // Backpressure for 4 cycles mid-burst.
    q0 = '{9'h0C1, 9'h0C2, 9'h1C3};
    sb = '{9'h0C1, 9'h0C2, 9'h1C3};
    cyc();
    cyc();
    chk("bp_gnt", 32'(gnt), 32'd1);
    ready_nxt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("bp_hold_data", 32'(out_data), 32'hC1);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_gnt", 32'(gnt), 32'd1);
    end
    ready_nxt = 1'b1;
    cyc();
    chk("bp_release_drain", 32'(out_data), 32'hC1);
    cyc();
    chk("bp_release_next", 32'(out_data), 32'hC2);
    chk("bp_release_valid", 32'(out_valid), 32'd1);
    drain("bp_drain");

    // Grant lock: requester 0 pauses while requester 1 waits.
    q0 = '{9'h0D1, 9'h0D2, 9'h1D3};
    sb = '{9'h0D1, 9'h0D2, 9'h1D3, 9'h1E1};
    cyc();
    cyc();
    chk("lock_gnt_start", 32'(gnt), 32'd1);
    q1 = '{9'h1E1};
    stall_nxt = 2'b01;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("lock_gnt", 32'(gnt), 32'd1);
      chk("lock_s", 32'(s), 32'd0);
    end
    stall_nxt = 2'b00;
    drain("lock_drain");

`ifdef ARB_TIMEOUT_EN
    // Stalled grant revoked after TO idle cycles.
    q0 = '{9'h0F1, 9'h1F2};
    sb = '{9'h0F1, 9'h1A7, 9'h1F2};
    cyc();
    cyc();
    chk("to_gnt_start", 32'(gnt), 32'd1);
    q1 = '{9'h1A7};
    stall_nxt = 2'b01;
    for (int k = 0; k < TO; k++) begin
      cyc();
      chk("to_hold_gnt", 32'(gnt), 32'd1);
      chk("to_flag_pre", 32'(timeout_flag), 32'd0);
    end
    cyc();
    chk("to_idle_gnt", 32'(gnt), 32'd0);
    chk("to_flag", 32'(timeout_flag), 32'd1);
    cyc();
    chk("to_regrant", 32'(gnt), 32'd2);
    chk("to_regrant_s", 32'(s), 32'd1);
    stall_nxt = 2'b00;
    drain("to_drain");
    chk("to_flag_sticky", 32'(timeout_flag), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
